// File: rtl/countdown_pkg.sv
// Shared types and helpers for the two-digit BCD countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Prescaler width; never below one bit so the counter always exists.
  function automatic int unsigned presc_width(input int unsigned div);
    int unsigned w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_down2.sv
// Two-digit BCD down-counter with saturating preset load and zero flags.
module bcd_down2
  import countdown_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       is_zero,
  output logic       is_zero_next
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  assign is_zero      = (tens_q == 4'd0) && (ones_q == 4'd0);
  // High when the next decrement would land on 00.
  assign is_zero_next = (tens_q == 4'd0) && (ones_q == 4'd1);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load) begin
      tens_d = bcd_sat(preset_tens);
      ones_d = bcd_sat(preset_ones);
    end else if (dec && !is_zero) begin
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else begin
        ones_d = BCD_MAX;
        tens_d = tens_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: run/pause FSM and tick prescaler driving a BCD down-counter.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          done_q, done_d;
  logic          dec;
  logic          cnt_zero, cnt_zero_next;

  bcd_down2 u_digits (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .preset_tens  (preset_tens),
    .preset_ones  (preset_ones),
    .dec          (dec),
    .tens         (tens),
    .ones         (ones),
    .is_zero      (cnt_zero),
    .is_zero_next (cnt_zero_next)
  );

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dec     = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !pause) begin
            if (cnt_zero) begin
              state_d = ST_EXPIRED;
            end else begin
              state_d = ST_RUN;
              presc_d = '0;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            dec     = 1'b1;
            if (cnt_zero_next) state_d = ST_EXPIRED;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSED: begin
          if (start && !pause) state_d = ST_RUN;
        end
        ST_EXPIRED: ;
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
    done_d    = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule
